rst_ckpt: RTL and testbench
===========================

Name: rst_ckpt

Overview:
- Parametrised register status table for the Tomasulo dispatch stage. Tracks, per architectural register, whether a result is pending and which tag will produce it.
- Generalises the single-CDB table to NUM_CDB broadcast buses and adds NUM_CKPT snapshot/restore slots for branch-misprediction recovery.
- Sits between the dispatch unit, the CDB arbiter(s) and the register file.

Parameters:
- NUM_REGS, 32, architectural registers; register 0 is hardwired (never pending).
- TAG_W, 6, tag width.
- NUM_CDB, 2, number of CDB ports cleared per cycle.
- NUM_CKPT, 4, snapshot slots.
- Localparams: AW = clog2(NUM_REGS); CW = max(1, clog2(NUM_CDB)); KW = max(1, clog2(NUM_CKPT)).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- dispatch_addr  in  AW  destination register.
- dispatch_tag  in  TAG_W  tag of the new producer.
- dispatch_wen  in  1  mark dispatch_addr pending with dispatch_tag.
- dispatch_rsaddr  in  AW  RS read address.
- dispatch_rstag  out  TAG_W  RS producer tag.
- dispatch_rsvalid  out  1  RS still pending.
- dispatch_rtaddr  in  AW  RT read address.
- dispatch_rttag  out  TAG_W  RT producer tag.
- dispatch_rtvalid  out  1  RT still pending.
- cdb_tag  in  NUM_CDB*TAG_W  broadcast tags; port p occupies bits [p*TAG_W +: TAG_W].
- cdb_valid  in  NUM_CDB  per-port broadcast valid.
- regfile_wen_onehot  out  NUM_REGS  register r takes the CDB value this cycle.
- regfile_wen_sel  out  NUM_REGS*CW  CDB port index that supplies register r.
- ckpt_save  in  1  snapshot the table into ckpt_save_id.
- ckpt_save_id  in  KW  snapshot slot.
- ckpt_release  in  NUM_CKPT  mask of slots to free.
- flush  in  1  restore the table from flush_id.
- flush_id  in  KW  slot to restore.
- ckpt_valid  out  NUM_CKPT  slot holds a live snapshot.
- flush_err  out  1  one-cycle pulse: previous flush targeted an invalid slot.

Behaviour:
- State:
  - Per-register entry {pend, tag}.
  - NUM_CKPT snapshot arrays of the same shape.
  - ckpt_valid, flush_err.
- Reset (reset=0, asynchronous):
  - All pend=0 and tags=0 in the table and every snapshot.
  - ckpt_valid=0, flush_err=0.
  - Reads return valid=0; regfile_wen_onehot=0.
- CDB match (combinational): hit[r][p] = pend[r] && cdb_valid[p] && tag[r]==cdb_tag[p].
  - Tags are unique in flight, so at most one p hits per r.
  - If several do hit, the lowest p wins.
- regfile_wen_onehot[r] = OR over p of hit[r][p]; regfile_wen_sel[r] = index of the winning p (0 when no hit). Bit 0 is always 0.
- Reads (combinational, zero latency):
  - tag = entry tag.
  - valid = pend && no CDB hit this cycle (same-cycle bypass).
  - Address 0 always returns valid=0, tag=0.
- Next table state, applied in priority order:
  1. Clear every entry with any hit.
  2. If dispatch_wen and dispatch_addr!=0 and dispatch_tag matches no valid cdb_tag, set that entry to {1, dispatch_tag}. This overrides a clear on the same register: the new producer wins.
  3. If dispatch_tag equals a valid cdb_tag, the write is suppressed; the entry ends with pend=0.
- Snapshot clears: each slot with ckpt_valid=1 applies the same CDB clears every cycle, so restored state never references completed tags.
- ckpt_save (when flush=0):
  - Slot ckpt_save_id <= next table state, including this cycle's dispatch write and clears.
  - ckpt_valid[id] <= 1. Overwriting a live slot is allowed.
- ckpt_release:
  - ckpt_valid[i] <= 0 for each set bit.
  - A save to the same id in the same cycle wins over its release.
- flush=1 with ckpt_valid[flush_id]=1:
  - Table <= snapshot[flush_id] with this cycle's CDB clears applied.
  - ckpt_valid[flush_id] <= 0.
  - Dispatch write and ckpt_save are ignored this cycle; ckpt_release is still honoured.
- flush=1 with ckpt_valid[flush_id]=0:
  - Table updates as normal except the dispatch write is dropped; no save.
  - flush_err=1 on the next cycle only.
- Combinational outputs (reads, regfile_wen_*) reflect the current table and current CDB inputs in every cycle, including the flush cycle.

Test Plan:
1. Reset (reset=0), then read rs=5, rt=0 -> rsvalid=0, rtvalid=0, ckpt_valid=4'b0000, regfile_wen_onehot=0.
2. Dispatch addr=5 tag=0x12. Next cycle drive cdb port1 tag=0x12 valid -> same cycle: rsvalid(5)=0 via bypass, regfile_wen_onehot[5]=1, regfile_wen_sel[5]=1. Following cycle: pend[5]=0.
3. Same cycle: dispatch addr=7 tag=0x20 and cdb port0 clears old tag 0x03 held in reg 7 -> reg 7 = {1, 0x20}, regfile_wen_onehot[7]=1. Dispatch addr=8 tag=0x21 with cdb_tag=0x21 valid -> reg 8 pend=0.
4. Dispatch addr=3 tag=0x05 with ckpt_save id=2 -> ckpt_valid[2]=1. Dispatch addr=3 tag=0x06, then broadcast 0x05, then flush id=2 -> reg 3 pend=0 (snapshot was cleared), ckpt_valid[2]=0.
5. Flush id=1 while ckpt_valid[1]=0, with dispatch_wen addr=4 -> reg 4 unchanged, flush_err=1 for exactly one cycle.
6. Assert reset mid-flush with two live slots -> all outputs cleared immediately, asynchronously; ckpt_valid=0.

Source files
------------

// File: rtl/rst_ckpt.sv
// Register status table for Tomasulo dispatch: per-register pending flag and producer tag,
// multi-port CDB clearing, and snapshot/restore slots for branch-misprediction recovery.
module rst_ckpt #(
   parameter  int NUM_REGS = 32,
   parameter  int TAG_W    = 6,
   parameter  int NUM_CDB  = 2,
   parameter  int NUM_CKPT = 4,
   localparam int AW       = $clog2(NUM_REGS),
   localparam int CW       = (NUM_CDB  > 1) ? $clog2(NUM_CDB)  : 1,
   localparam int KW       = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [AW-1:0]             dispatch_addr,
   input  logic [TAG_W-1:0]          dispatch_tag,
   input  logic                      dispatch_wen,
   input  logic [AW-1:0]             dispatch_rsaddr,
   output logic [TAG_W-1:0]          dispatch_rstag,
   output logic                      dispatch_rsvalid,
   input  logic [AW-1:0]             dispatch_rtaddr,
   output logic [TAG_W-1:0]          dispatch_rttag,
   output logic                      dispatch_rtvalid,
   input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
   input  logic [NUM_CDB-1:0]        cdb_valid,
   output logic [NUM_REGS-1:0]       regfile_wen_onehot,
   output logic [NUM_REGS*CW-1:0]    regfile_wen_sel,
   input  logic                      ckpt_save,
   input  logic [KW-1:0]             ckpt_save_id,
   input  logic [NUM_CKPT-1:0]       ckpt_release,
   input  logic                      flush,
   input  logic [KW-1:0]             flush_id,
   output logic [NUM_CKPT-1:0]       ckpt_valid,
   output logic                      flush_err
);

   logic [NUM_REGS-1:0] pend_q;
   logic [TAG_W-1:0]    tag_q [NUM_REGS];
   logic [NUM_REGS-1:0] snap_pend [NUM_CKPT];
   logic [TAG_W-1:0]    snap_tag  [NUM_CKPT][NUM_REGS];

   logic [NUM_REGS-1:0] hit_any;
   logic [CW-1:0]       hit_sel [NUM_REGS];
   logic [NUM_REGS-1:0] snap_hit [NUM_CKPT];
   logic                disp_hit;
   logic                flush_ok;
   logic                save_go;
   logic [NUM_REGS-1:0] nxt_pend;
   logic [TAG_W-1:0]    nxt_tag [NUM_REGS];
   logic [NUM_CKPT-1:0] nxt_valid;

   // Live-table CDB match; the ascending scan with !hit_any lets the lowest port win.
   always_comb begin
      hit_any = '0;
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
         hit_sel[r] = '0;
         if (r != 0) begin
            for (int unsigned p = 0; p < NUM_CDB; p++) begin
               if (pend_q[r] && cdb_valid[p] && !hit_any[r] &&
                   tag_q[r] == cdb_tag[p*TAG_W +: TAG_W]) begin
                  hit_any[r] = 1'b1;
                  hit_sel[r] = CW'(p);
               end
            end
         end
      end
   end

   always_comb begin
      for (int unsigned k = 0; k < NUM_CKPT; k++) begin
         snap_hit[k] = '0;
         for (int unsigned r = 1; r < NUM_REGS; r++) begin
            for (int unsigned p = 0; p < NUM_CDB; p++) begin
               if (snap_pend[k][r] && cdb_valid[p] &&
                   snap_tag[k][r] == cdb_tag[p*TAG_W +: TAG_W])
                  snap_hit[k][r] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      disp_hit = 1'b0;
      for (int unsigned p = 0; p < NUM_CDB; p++) begin
         if (cdb_valid[p] && cdb_tag[p*TAG_W +: TAG_W] == dispatch_tag)
            disp_hit = 1'b1;
      end
   end

   assign flush_ok = flush && ckpt_valid[flush_id];
   assign save_go  = ckpt_save && !flush;

   always_comb begin
      nxt_pend = pend_q & ~hit_any;
      for (int unsigned r = 0; r < NUM_REGS; r++)
         nxt_tag[r] = tag_q[r];
      if (flush_ok) begin
         nxt_pend = snap_pend[flush_id] & ~snap_hit[flush_id];
         for (int unsigned r = 0; r < NUM_REGS; r++)
            nxt_tag[r] = snap_tag[flush_id][r];
      end else if (dispatch_wen && !flush && dispatch_addr != '0) begin
         // A producer whose tag is already on the CDB leaves nothing pending.
         if (disp_hit) begin
            nxt_pend[dispatch_addr] = 1'b0;
         end else begin
            nxt_pend[dispatch_addr] = 1'b1;
            nxt_tag[dispatch_addr]  = dispatch_tag;
         end
      end
      nxt_pend[0] = 1'b0;
      nxt_tag[0]  = '0;
   end

   always_comb begin
      nxt_valid = ckpt_valid & ~ckpt_release;
      if (save_go)
         nxt_valid[ckpt_save_id] = 1'b1;
      if (flush_ok)
         nxt_valid[flush_id] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_q     <= '0;
         ckpt_valid <= '0;
         flush_err  <= 1'b0;
         for (int unsigned r = 0; r < NUM_REGS; r++)
            tag_q[r] <= '0;
         for (int unsigned k = 0; k < NUM_CKPT; k++) begin
            snap_pend[k] <= '0;
            for (int unsigned r = 0; r < NUM_REGS; r++)
               snap_tag[k][r] <= '0;
         end
      end else begin
         pend_q     <= nxt_pend;
         ckpt_valid <= nxt_valid;
         flush_err  <= flush && !ckpt_valid[flush_id];
         for (int unsigned r = 0; r < NUM_REGS; r++)
            tag_q[r] <= nxt_tag[r];
         for (int unsigned k = 0; k < NUM_CKPT; k++) begin
            if (save_go && ckpt_save_id == KW'(k)) begin
               snap_pend[k] <= nxt_pend;
               for (int unsigned r = 0; r < NUM_REGS; r++)
                  snap_tag[k][r] <= nxt_tag[r];
            end else if (ckpt_valid[k]) begin
               snap_pend[k] <= snap_pend[k] & ~snap_hit[k];
            end
         end
      end
   end

   always_comb begin
      regfile_wen_onehot = hit_any;
      regfile_wen_sel    = '0;
      for (int unsigned r = 0; r < NUM_REGS; r++)
         regfile_wen_sel[r*CW +: CW] = hit_sel[r];
   end

   always_comb begin
      dispatch_rsvalid = 1'b0;
      dispatch_rstag   = '0;
      dispatch_rtvalid = 1'b0;
      dispatch_rttag   = '0;
      if (dispatch_rsaddr != '0) begin
         dispatch_rsvalid = pend_q[dispatch_rsaddr] && !hit_any[dispatch_rsaddr];
         dispatch_rstag   = tag_q[dispatch_rsaddr];
      end
      if (dispatch_rtaddr != '0) begin
         dispatch_rtvalid = pend_q[dispatch_rtaddr] && !hit_any[dispatch_rtaddr];
         dispatch_rttag   = tag_q[dispatch_rtaddr];
      end
   end

endmodule

// File: tb/tb_rst_ckpt.sv
// Bench for rst_ckpt: tag-set behavioural model compared every cycle, plus literal
// expectations for the directed scenarios.
module tb_rst_ckpt;

   localparam int NR = 32;
   localparam int TW = 6;
   localparam int NC = 2;
   localparam int NK = 4;

   logic           clk;
   logic           reset;
   logic [4:0]     dispatch_addr;
   logic [TW-1:0]  dispatch_tag;
   logic           dispatch_wen;
   logic [4:0]     dispatch_rsaddr;
   logic [TW-1:0]  dispatch_rstag;
   logic           dispatch_rsvalid;
   logic [4:0]     dispatch_rtaddr;
   logic [TW-1:0]  dispatch_rttag;
   logic           dispatch_rtvalid;
   logic [NC*TW-1:0] cdb_tag;
   logic [NC-1:0]  cdb_valid;
   logic [NR-1:0]  regfile_wen_onehot;
   logic [NR-1:0]  regfile_wen_sel;
   logic           ckpt_save;
   logic [1:0]     ckpt_save_id;
   logic [NK-1:0]  ckpt_release;
   logic           flush;
   logic [1:0]     flush_id;
   logic [NK-1:0]  ckpt_valid;
   logic           flush_err;

   rst_ckpt #(.NUM_REGS(NR), .TAG_W(TW), .NUM_CDB(NC), .NUM_CKPT(NK)) dut (
      .clk(clk), .reset(reset),
      .dispatch_addr(dispatch_addr), .dispatch_tag(dispatch_tag), .dispatch_wen(dispatch_wen),
      .dispatch_rsaddr(dispatch_rsaddr), .dispatch_rstag(dispatch_rstag),
      .dispatch_rsvalid(dispatch_rsvalid),
      .dispatch_rtaddr(dispatch_rtaddr), .dispatch_rttag(dispatch_rttag),
      .dispatch_rtvalid(dispatch_rtvalid),
      .cdb_tag(cdb_tag), .cdb_valid(cdb_valid),
      .regfile_wen_onehot(regfile_wen_onehot), .regfile_wen_sel(regfile_wen_sel),
      .ckpt_save(ckpt_save), .ckpt_save_id(ckpt_save_id), .ckpt_release(ckpt_release),
      .flush(flush), .flush_id(flush_id), .ckpt_valid(ckpt_valid), .flush_err(flush_err)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model state: live table, snapshot tables, slot validity, error pulse.
   bit         m_pend [NR];
   bit [TW-1:0] m_tag [NR];
   bit         m_sp [NK][NR];
   bit [TW-1:0] m_st [NK][NR];
   bit [NK-1:0] m_cv;
   bit         m_ferr;

   always @(negedge clk) begin
      bit          bc [64];
      bit          np [NR];
      bit [TW-1:0] nt [NR];
      bit [NR-1:0] e_one;
      bit [NR-1:0] e_sel;
      bit          ok;
      bit [NK-1:0] ncv;
      logic [TW-1:0] pt;
      if (!reset) begin
         for (int r = 0; r < NR; r++) begin
            m_pend[r] = 0; m_tag[r] = '0;
            for (int k = 0; k < NK; k++) begin m_sp[k][r] = 0; m_st[k][r] = '0; end
         end
         m_cv = '0; m_ferr = 0;
         chk("rst_rsvalid", dispatch_rsvalid, 0);
         chk("rst_rtvalid", dispatch_rtvalid, 0);
         chk("rst_onehot", regfile_wen_onehot, 0);
         chk("rst_ckpt_valid", ckpt_valid, 0);
         chk("rst_flush_err", flush_err, 0);
      end else begin
         // Set of tags being broadcast this cycle.
         for (int t = 0; t < 64; t++) bc[t] = 0;
         for (int p = 0; p < NC; p++)
            if (cdb_valid[p]) begin pt = cdb_tag[p*TW +: TW]; bc[pt] = 1; end
         e_one = '0; e_sel = '0;
         for (int r = 1; r < NR; r++) begin
            if (m_pend[r] && bc[m_tag[r]]) begin
               e_one[r] = 1;
               ok = 0;
               for (int p = 0; p < NC; p++)
                  if (!ok && cdb_valid[p] && cdb_tag[p*TW +: TW] == m_tag[r]) begin
                     ok = 1; e_sel[r] = 1'(p);
                  end
            end
         end
         chk("onehot", regfile_wen_onehot, e_one);
         chk("wen_sel", regfile_wen_sel, e_sel);
         chk("ckpt_valid", ckpt_valid, m_cv);
         chk("flush_err", flush_err, m_ferr);
         chk("rsvalid", dispatch_rsvalid,
             dispatch_rsaddr != 0 && m_pend[dispatch_rsaddr] && !bc[m_tag[dispatch_rsaddr]]);
         chk("rtvalid", dispatch_rtvalid,
             dispatch_rtaddr != 0 && m_pend[dispatch_rtaddr] && !bc[m_tag[dispatch_rtaddr]]);
         if (dispatch_rsaddr == 0) chk("rstag0", dispatch_rstag, 0);
         else if (m_pend[dispatch_rsaddr]) chk("rstag", dispatch_rstag, m_tag[dispatch_rsaddr]);
         if (dispatch_rtaddr == 0) chk("rttag0", dispatch_rttag, 0);
         else if (m_pend[dispatch_rtaddr]) chk("rttag", dispatch_rttag, m_tag[dispatch_rtaddr]);

         // Advance the model by one clock.
         ok = flush && m_cv[flush_id];
         for (int r = 0; r < NR; r++) begin
            if (ok) begin
               np[r] = m_sp[flush_id][r] && !bc[m_st[flush_id][r]];
               nt[r] = m_st[flush_id][r];
            end else begin
               np[r] = m_pend[r] && !bc[m_tag[r]];
               nt[r] = m_tag[r];
            end
         end
         if (!flush && dispatch_wen && dispatch_addr != 0) begin
            if (bc[dispatch_tag]) np[dispatch_addr] = 0;
            else begin np[dispatch_addr] = 1; nt[dispatch_addr] = dispatch_tag; end
         end
         for (int k = 0; k < NK; k++)
            if (m_cv[k])
               for (int r = 0; r < NR; r++)
                  if (m_sp[k][r] && bc[m_st[k][r]]) m_sp[k][r] = 0;
         ncv = m_cv & ~ckpt_release;
         if (ckpt_save && !flush) begin
            for (int r = 0; r < NR; r++) begin
               m_sp[ckpt_save_id][r] = np[r];
               m_st[ckpt_save_id][r] = nt[r];
            end
            ncv[ckpt_save_id] = 1;
         end
         if (ok) ncv[flush_id] = 0;
         m_ferr = flush && !m_cv[flush_id];
         m_cv = ncv;
         for (int r = 0; r < NR; r++) begin m_pend[r] = np[r]; m_tag[r] = nt[r]; end
      end
   end

   task automatic idle();
      dispatch_wen = 0; dispatch_addr = '0; dispatch_tag = '0;
      cdb_valid = '0; cdb_tag = '0;
      ckpt_save = 0; ckpt_save_id = '0; ckpt_release = '0;
      flush = 0; flush_id = '0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic disp(input int a, input int t);
      dispatch_wen = 1; dispatch_addr = 5'(a); dispatch_tag = 6'(t);
   endtask

   task automatic bcast(input int p, input int t);
      cdb_valid[p] = 1'b1; cdb_tag[p*TW +: TW] = 6'(t);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 0;
      idle();
      dispatch_rsaddr = 5'd5; dispatch_rtaddr = 5'd0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      // 1. reset state
      chk("t1_rsvalid", dispatch_rsvalid, 0);
      chk("t1_rtvalid", dispatch_rtvalid, 0);
      chk("t1_ckpt_valid", ckpt_valid, 4'b0000);
      chk("t1_onehot", regfile_wen_onehot, 0);
      reset = 1;

      // 2. dispatch then same-cycle bypass on CDB port 1
      disp(5, 'h12);
      cyc();
      #2 chk("t2_pending", dispatch_rsvalid, 1);
      chk("t2_tag", dispatch_rstag, 'h12);
      bcast(1, 'h12);
      #1 chk("t2_bypass", dispatch_rsvalid, 0);
      chk("t2_onehot5", regfile_wen_onehot[5], 1);
      chk("t2_sel5", regfile_wen_sel[5], 1);
      cyc();
      #2 chk("t2_cleared", dispatch_rsvalid, 0);

      // 3. new producer beats same-cycle clear; dispatch of a broadcasting tag
      disp(7, 'h03);
      cyc();
      disp(7, 'h20); bcast(0, 'h03);
      #2 chk("t3_onehot7", regfile_wen_onehot[7], 1);
      cyc();
      dispatch_rsaddr = 5'd7;
      #2 chk("t3_r7_valid", dispatch_rsvalid, 1);
      chk("t3_r7_tag", dispatch_rstag, 'h20);
      disp(8, 'h21); bcast(0, 'h21);
      cyc();
      dispatch_rsaddr = 5'd8;
      #2 chk("t3_r8_valid", dispatch_rsvalid, 0);

      // 4. save, redispatch, broadcast old tag, restore
      disp(3, 'h05); ckpt_save = 1; ckpt_save_id = 2'd2;
      cyc();
      #2 chk("t4_saved", ckpt_valid, 4'b0100);
      disp(3, 'h06);
      cyc();
      bcast(0, 'h05);
      cyc();
      flush = 1; flush_id = 2'd2;
      cyc();
      dispatch_rsaddr = 5'd3; dispatch_rtaddr = 5'd7;
      #2 chk("t4_r3_valid", dispatch_rsvalid, 0);
      chk("t4_ckpt_valid", ckpt_valid, 4'b0000);
      chk("t4_r7_kept", dispatch_rtvalid, 1);

      // 5. flush of an empty slot drops the dispatch and pulses flush_err once
      disp(4, 'h30);
      cyc();
      flush = 1; flush_id = 2'd1; disp(4, 'h31);
      cyc();
      dispatch_rsaddr = 5'd4;
      #2 chk("t5_err", flush_err, 1);
      chk("t5_r4_tag", dispatch_rstag, 'h30);
      chk("t5_r4_valid", dispatch_rsvalid, 1);
      cyc();
      #2 chk("t5_err_gone", flush_err, 0);

      // Directed mixed traffic, checked by the model every cycle.
      for (int i = 0; i < 60; i++) begin
         if (i % 3 != 2) disp((i * 7) % 32, (i * 5 + 1) % 64);
         if (i % 2 == 0) bcast(0, ((i - 2) * 5 + 1 + 640) % 64);
         if (i % 4 == 1) bcast(1, ((i - 3) * 5 + 1 + 640) % 64);
         if (i % 10 == 7) begin bcast(0, ((i - 1) * 5 + 1) % 64); bcast(1, ((i - 1) * 5 + 1) % 64); end
         if (i % 8 == 3) begin ckpt_save = 1; ckpt_save_id = 2'((i / 8) % 4); end
         if (i % 16 == 9) ckpt_release = 4'b0101;
         if (i % 12 == 11) begin flush = 1; flush_id = 2'((i / 12) % 4); end
         dispatch_rsaddr = 5'((i * 11) % 32);
         dispatch_rtaddr = 5'((i * 13) % 32);
         cyc();
      end

      // 6. asynchronous reset in the middle of a flush with two live slots
      ckpt_release = 4'b1111;
      cyc();
      cyc();
      disp(9, 'h09); ckpt_save = 1; ckpt_save_id = 2'd0;
      cyc();
      ckpt_save = 1; ckpt_save_id = 2'd1;
      cyc();
      dispatch_rsaddr = 5'd9;
      #2 chk("t6_live", ckpt_valid, 4'b0011);
      chk("t6_r9_valid", dispatch_rsvalid, 1);
      cyc();
      flush = 1; flush_id = 2'd0; bcast(0, 'h09);
      #1 chk("t6_onehot_pre", regfile_wen_onehot[9], 1);
      reset = 0;
      #1 chk("t6_onehot", regfile_wen_onehot, 0);
      chk("t6_ckpt_valid", ckpt_valid, 0);
      chk("t6_rsvalid", dispatch_rsvalid, 0);
      chk("t6_flush_err", flush_err, 0);
      cyc();
      reset = 1;
      cyc();
      cyc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
